// File: rtl/fetch_seq_pkg.sv
// Shared definitions for the fetch sequencer: FSM state encodings, UART
// command bytes and the default halt opcode / drain length.
package fetch_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_RESTART = 3'd2,
        ST_RUN     = 3'd3,
        ST_STEP    = 3'd4,
        ST_DRAIN   = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
    localparam logic [7:0] CMD_CONT = 8'h43;  // 'C'
    localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'
    localparam logic [7:0] CMD_NEXT = 8'h4E;  // 'N'

    localparam logic [31:0] HALT_INSTR_DEFAULT   = 32'hFFFF_FFFF;
    localparam int          DRAIN_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/byte_word_packer.sv
// Packs four UART bytes, MSB first, into one instruction word.
// Ports:
//   i_clk, i_rst     clock, synchronous active-low reset
//   i_clear          synchronous clear of word, byte counter and strobe
//   i_byte_valid     shift i_byte in this cycle
//   i_byte           received byte
//   o_word           packed word (stable while o_word_valid is high)
//   o_word_valid     one-cycle pulse, the cycle after the 4th byte
module byte_word_packer #(
    parameter int LEN = 32
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_clear,
    input  logic           i_byte_valid,
    input  logic [7:0]     i_byte,
    output logic [LEN-1:0] o_word,
    output logic           o_word_valid
);

    logic [LEN-1:0] r_word;
    logic [1:0]     r_byte_cnt;
    logic           r_word_valid;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (!i_rst || i_clear) begin
            r_word       <= '0;
            r_byte_cnt   <= 2'd0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            if (i_byte_valid) begin
                r_word     <= {r_word[LEN-9:0], i_byte};
                r_byte_cnt <= r_byte_cnt + 2'd1;
                if (r_byte_cnt == 2'd3) begin
                    r_word_valid <= 1'b1;
                end
            end
        end
    end

    assign o_word       = r_word;
    assign o_word_valid = r_word_valid;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: loads a program from the UART RX stream into instruction
// RAM, then runs the PC/pipeline continuously or single-stepped until the
// HALT word reaches the IF output register, drains the pipeline and stops.
// Ports:
//   i_clk, i_rst              clock, synchronous active-low reset
//   i_rx_data, i_rx_valid     UART byte and its one-cycle strobe
//   i_instr                   instruction in the IF output register
//   o_im_we/addr/data         instruction RAM port A write
//   o_core_rst_n              active-low reset to PC and pipeline
//   o_pc_en, o_pipe_en        PC and pipeline register enables
//   o_state                   current FSM state
//   o_load_err                sticky load overflow flag
//   o_cycle_count             saturating count of enabled pipeline cycles
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int          LEN          = 32,
    parameter int          ADDR_W       = 11,
    parameter logic [31:0] HALT_INSTR   = HALT_INSTR_DEFAULT,
    parameter int          DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    input  logic [LEN-1:0]    i_instr,
    output logic              o_im_we,
    output logic [ADDR_W-1:0] o_im_addr,
    output logic [LEN-1:0]    o_im_data,
    output logic              o_core_rst_n,
    output logic              o_pc_en,
    output logic              o_pipe_en,
    output logic [2:0]        o_state,
    output logic              o_load_err,
    output logic [31:0]       o_cycle_count
);

    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);

    state_t            r_state, w_next_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_load_err;
    logic [31:0]       r_cycle_count;
    logic [7:0]        r_drain_cnt;
    logic              r_mode_step;
    logic              r_step_pulse;

    logic           w_rx_load, w_rx_cont, w_rx_step, w_rx_next;
    logic           w_halt, w_cmd_state, w_start_load;
    logic           w_word_valid, w_word_halt, w_addr_last;
    logic [LEN-1:0] w_word;
    logic           w_im_we, w_core_rst_n, w_pc_en, w_pipe_en;

    assign w_rx_load = i_rx_valid && (i_rx_data == CMD_LOAD);
    assign w_rx_cont = i_rx_valid && (i_rx_data == CMD_CONT);
    assign w_rx_step = i_rx_valid && (i_rx_data == CMD_STEP);
    assign w_rx_next = i_rx_valid && (i_rx_data == CMD_NEXT);

    assign w_halt       = (i_instr == HALT_INSTR);
    assign w_cmd_state  = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_start_load = w_cmd_state && w_rx_load;
    assign w_word_halt  = (w_word == HALT_INSTR);
    assign w_addr_last  = &r_addr;

    byte_word_packer #(.LEN(LEN)) u_packer (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clear      (w_start_load),
        .i_byte_valid (i_rx_valid && (r_state == ST_LOAD)),
        .i_byte       (i_rx_data),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_im_we      = 1'b0;
        w_core_rst_n = 1'b1;
        w_pc_en      = 1'b0;
        w_pipe_en    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_core_rst_n = 1'b0;
                if (w_rx_load)                   w_next_state = ST_LOAD;
                else if (w_rx_cont || w_rx_step) w_next_state = ST_RESTART;
            end
            ST_LOAD: begin
                w_core_rst_n = 1'b0;
                w_im_we      = w_word_valid;
                // A HALT word or the last RAM address ends the load.
                if (w_word_valid && (w_word_halt || w_addr_last)) w_next_state = ST_IDLE;
            end
            ST_RESTART: begin
                w_core_rst_n = 1'b0;
                w_next_state = r_mode_step ? ST_STEP : ST_RUN;
            end
            ST_RUN: begin
                w_pc_en   = 1'b1;
                w_pipe_en = 1'b1;
                if (w_halt) w_next_state = ST_DRAIN;
            end
            ST_STEP: begin
                w_pc_en   = r_step_pulse;
                w_pipe_en = r_step_pulse;
                if (w_halt)         w_next_state = ST_DRAIN;
                else if (w_rx_cont) w_next_state = ST_RUN;
            end
            ST_DRAIN: begin
                w_pipe_en = 1'b1;
                if (r_drain_cnt == DRAIN_LAST) w_next_state = ST_DONE;
            end
            ST_DONE: begin
                if (w_rx_load)                   w_next_state = ST_LOAD;
                else if (w_rx_cont || w_rx_step) w_next_state = ST_RESTART;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state       <= ST_IDLE;
            r_addr        <= '0;
            r_load_err    <= 1'b0;
            r_cycle_count <= '0;
            r_drain_cnt   <= 8'd0;
            r_mode_step   <= 1'b0;
            r_step_pulse  <= 1'b0;
        end else begin
            r_state <= w_next_state;

            if (w_start_load) begin
                r_addr     <= '0;
                r_load_err <= 1'b0;
            end else if (w_im_we) begin
                // The address never wraps; a non-HALT write at the top is an overflow.
                if (!w_addr_last)      r_addr     <= r_addr + 1'b1;
                else if (!w_word_halt) r_load_err <= 1'b1;
            end

            if (w_cmd_state && (w_rx_cont || w_rx_step)) r_mode_step <= w_rx_step;

            // HALT wins over a simultaneous 'N', which is then dropped.
            r_step_pulse <= (r_state == ST_STEP) && w_rx_next && !w_halt;

            if (r_state == ST_RESTART)                   r_cycle_count <= '0;
            else if (w_pipe_en && (r_cycle_count != '1)) r_cycle_count <= r_cycle_count + 32'd1;

            r_drain_cnt <= (r_state == ST_DRAIN) ? r_drain_cnt + 8'd1 : 8'd0;
        end
    end

    assign o_im_we       = w_im_we;
    assign o_im_addr     = r_addr;
    assign o_im_data     = w_im_we ? w_word : '0;
    assign o_core_rst_n  = w_core_rst_n;
    assign o_pc_en       = w_pc_en;
    assign o_pipe_en     = w_pipe_en;
    assign o_state       = r_state;
    assign o_load_err    = r_load_err;
    assign o_cycle_count = r_cycle_count;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences the instruction-fetch stage and the pipeline behind it.
- Loads a program, byte by byte from the UART RX stream, into the instruction RAM write port.
- Then releases the PC and pipeline in continuous or single-step mode, and stops them when the HALT word reaches the IF output register.
- Sits between the UART RX, the instruction RAM port A write inputs (wea/addra/dina), and the PC/pipeline enable and reset inputs.

Parameters:
- LEN, 32, instruction/data width.
- ADDR_W, 11, instruction RAM word-address width (depth 2048).
- HALT_INSTR, 32'hFFFFFFFF, halt opcode.
- DRAIN_CYCLES, 4, pipeline cycles run after PC freeze so in-flight instructions retire.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  reset, synchronous, active-low.
- i_rx_data  in  8  received UART byte.
- i_rx_valid  in  1  one-cycle strobe, i_rx_data valid.
- i_instr  in  LEN  instruction currently held in the IF output register.
- o_im_we  out  1  instruction RAM write strobe.
- o_im_addr  out  ADDR_W  instruction RAM word address.
- o_im_data  out  LEN  instruction RAM write data.
- o_core_rst_n  out  1  active-low reset to PC and pipeline registers.
- o_pc_en  out  1  PC update enable.
- o_pipe_en  out  1  pipeline register enable.
- o_state  out  3  current state encoding.
- o_load_err  out  1  sticky: load overflowed RAM without HALT.
- o_cycle_count  out  32  executed pipeline cycles.

Behaviour:
- Reset (i_rst=0, any state, mid-operation included):
  - State IDLE.
  - o_im_we=0, o_im_addr=0, o_im_data=0, o_core_rst_n=0, o_pc_en=0, o_pipe_en=0.
  - o_load_err=0, o_cycle_count=0.
  - Byte packer cleared.
- Commands: 'L'=8'h4C, 'C'=8'h43, 'S'=8'h53, 'N'=8'h4E. Commands are accepted only in IDLE, DONE and STEP as listed below; any other byte is ignored.
- State encodings: IDLE=0, LOAD=1, RESTART=2, RUN=3, STEP=4, DRAIN=5, DONE=6.
- IDLE:
  - o_core_rst_n=0.
  - 'L' -> LOAD, with o_im_addr cleared, packer cleared, o_load_err cleared.
  - 'C' or 'S' -> RESTART, remembering the target mode.
- LOAD:
  - o_core_rst_n=0.
  - Every valid byte is shifted into the packer, MSB first; a byte is accepted every cycle, no stall.
  - When the 4th byte is received in cycle t, cycle t+1 has o_im_we=1, o_im_data=the word, o_im_addr=current address; the address increments after that cycle.
  - If the written word equals HALT_INSTR -> IDLE. o_im_addr then equals the number of words loaded.
  - If the write at address 2^ADDR_W-1 is not HALT -> IDLE with o_load_err=1; the address does not wrap.
- RESTART (one cycle):
  - o_core_rst_n=0; o_cycle_count cleared.
  - Next state is RUN or STEP.
- RUN:
  - o_core_rst_n=1, o_pc_en=1, o_pipe_en=1.
  - If i_instr==HALT_INSTR is sampled in cycle t -> DRAIN in t+1 with o_pc_en=0 from t+1.
  - RX bytes are ignored.
- STEP:
  - o_pc_en=o_pipe_en=0 except in the cycle after an 'N' is received, where both are 1 for exactly one cycle.
  - HALT detected on i_instr after a step -> DRAIN.
  - 'C' -> RUN without reset.
- DRAIN:
  - o_pc_en=0, o_pipe_en=1 for exactly DRAIN_CYCLES cycles, then DONE.
- DONE:
  - o_core_rst_n=1, o_pc_en=0, o_pipe_en=0; pipeline contents are preserved.
  - 'L' -> LOAD (with o_core_rst_n=0 from LOAD onward).
  - 'C' or 'S' -> RESTART.
- o_cycle_count increments every cycle o_pipe_en=1 and saturates at 32'hFFFFFFFF.
- Simultaneous events: a HALT match and an 'N' byte in the same STEP cycle gives HALT priority (-> DRAIN); the 'N' is dropped.

Decomposition:
- Shared package fetch_seq_pkg holds:
  - state encodings;
  - command byte constants;
  - HALT_INSTR default.
- Sub-module byte_word_packer:
  - 8-bit shift-in, 2-bit byte counter, one-cycle word-valid pulse, synchronous clear.
- Everything else lives in the FSM plus address and cycle counters in fetch_sequencer.

Test Plan:
- 1. Load:
  - Stimulus: reset, 'L', bytes 20 01 00 05, then FF FF FF FF.
  - Required: two o_im_we pulses with (addr 0, 32'h20010005) and (addr 1, 32'hFFFFFFFF); state returns to IDLE; o_im_addr=2; o_load_err=0.
- 2. Continuous run:
  - Stimulus: after test 1, 'C'; drive i_instr=HALT on the 6th RUN cycle.
  - Required: one RESTART cycle with o_core_rst_n=0; o_pc_en drops the next cycle; o_pipe_en stays high 4 more cycles; DONE; o_cycle_count=10.
- 3. Single step:
  - Stimulus: 'S', then three 'N' bytes spaced 5 cycles apart.
  - Required: exactly three single-cycle o_pc_en/o_pipe_en pulses, each one cycle after its 'N'; o_cycle_count=3.
- 4. Load overflow (ADDR_W=2):
  - Stimulus: load 4 non-HALT words.
  - Required: writes at addresses 0..3, then IDLE with o_load_err=1; a following 'L' clears o_load_err.
- 5. Reset mid-load:
  - Stimulus: i_rst=0 after 2 bytes of a word, then reload.
  - Required: all outputs at reset values; the next load's first word is packed from fresh bytes only.
- 6. Ignored bytes and priority:
  - Stimulus: 'N' in IDLE; 'L' in RUN; HALT plus 'N' in the same STEP cycle.
  - Required: no state change for the first two; the third goes to DRAIN with no extra step pulse.
